// File: rtl/jt51_opx.sv
// jt51_opx: 7-stage pipelined FM operator, 4 ops x CH channels, slot order derived from slot_sync, gated by cen.
// Define JT51_OPX_MODSAT_EN to saturate stage-I modulation to signed 20 bits instead of wrapping.
module jt51_opx #(
    parameter int unsigned CH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cen,
    input  logic               slot_sync,
    input  logic [19:0]        phase_cnt,
    input  logic [2:0]         con,
    input  logic [2:0]         fb,
    input  logic [9:0]         eg,
    output logic signed [13:0] out,
    output logic               out_valid,
    output logic [3:0]         out_ch,
    output logic [1:0]         out_op
);
    localparam int unsigned FRAME = 4 * CH;
    localparam int unsigned SW    = $clog2(FRAME);

    // History written in stage VI must land before the next reader, which is at least CH slots later
    if (CH < 6 || CH > 16) begin : g_ch_range
        $error("jt51_opx: CH must be within 6..16");
    end

    // Log-sine and exp ROM contents (arithmetic form of the quarter-wave tables)
    function automatic logic [11:0] sin_log(input logic [7:0] a);
        return 12'((16'(8'hFF - a) * 16'(8'hFF - a)) >> 4);
    endfunction

    function automatic logic [12:0] exp_pow(input logic [7:0] a);
        return 13'h1FFF - {1'b0, a, 4'b0000};
    endfunction

    logic [SW-1:0]      cnt_q, cnt_d, slot;
    logic [1:0]         op;
    logic [3:0]         ch;
    logic [SW-1:0]      i_m1, i_m2, i_c1;
    logic signed [13:0] hist_cur_q  [FRAME];
    logic signed [13:0] hist_prev_q [FRAME];
    logic signed [13:0] h_a, h_b;
    logic signed [14:0] mod_sum;
    logic [3:0]         mod_sh;
    logic [19:0]        mod;
`ifdef JT51_OPX_MODSAT_EN
    logic signed [24:0] mod_wide;
`endif
    logic [9:0]         phase_d;
    logic               car_d;

    logic [9:0]         s1_phase_q, s1_eg_q;
    logic [SW-1:0]      s1_slot_q;
    logic               s1_car_q;
    logic [7:0]         s2_addr_q;
    logic [9:0]         s2_eg_q;
    logic               s2_sign_q, s2_car_q;
    logic [SW-1:0]      s2_slot_q;
    logic [12:0]        s3_logsum_d;
    logic [4:0]         s3_msb_q;
    logic [7:0]         s3_paddr_q;
    logic               s3_sign_q, s3_car_q;
    logic [SW-1:0]      s3_slot_q;
    logic [12:0]        s4_pre_q;
    logic [4:0]         s4_msb_q;
    logic               s4_sign_q, s4_car_q;
    logic [SW-1:0]      s4_slot_q;
    logic [12:0]        s5_abs_d, s5_abs_q;
    logic               s5_sign_q, s5_car_q;
    logic [SW-1:0]      s5_slot_q;
    logic signed [13:0] s6_v_d, s6_v_q;
    logic               s6_car_q;
    logic [SW-1:0]      s6_slot_q;
    logic [2:0]         vcnt_q;

    always_comb begin
        slot  = slot_sync ? '0 : cnt_q;
        cnt_d = (32'(slot) == FRAME - 1) ? '0 : slot + SW'(1);
        op    = 2'(32'(slot) / CH);
        ch    = 4'(32'(slot) % CH);
        i_m1  = SW'(ch);
        i_m2  = SW'(32'(ch) + CH);
        i_c1  = SW'(32'(ch) + 2 * CH);
    end

    // Stage I: pick up to two history operands, sum at 15 bits, then scale
    always_comb begin
        h_a    = '0;
        h_b    = '0;
        mod_sh = 4'd9;
        unique case (op)
            2'd0: if (fb != 3'd0) begin
                h_a    = hist_cur_q[i_m1];
                h_b    = hist_prev_q[i_m1];
                mod_sh = {1'b0, fb};
            end
            2'd1: unique case (con)
                3'd1:       begin h_a = hist_cur_q[i_c1]; h_b = hist_cur_q[i_m1]; end
                3'd5:       h_a = hist_cur_q[i_m1];
                3'd0, 3'd2: h_a = hist_cur_q[i_c1];
                default:    ;
            endcase
            2'd2: if (!(con inside {3'd1, 3'd2, 3'd7})) h_a = hist_cur_q[i_m1];
            default: unique case (con)
                3'd2:       begin h_a = hist_cur_q[i_m1]; h_b = hist_cur_q[i_m2]; end
                3'd3:       begin h_a = hist_cur_q[i_m2]; h_b = hist_cur_q[i_c1]; end
                3'd5:       h_a = hist_cur_q[i_m1];
                3'd6, 3'd7: ;
                default:    h_a = hist_cur_q[i_m2];
            endcase
        endcase
        mod_sum = 15'(h_a) + 15'(h_b);
`ifdef JT51_OPX_MODSAT_EN
        mod_wide = 25'(mod_sum) <<< mod_sh;
        if (mod_wide > 25'sd524287)       mod = 20'h7FFFF;
        else if (mod_wide < -25'sd524288) mod = 20'h80000;
        else                              mod = mod_wide[19:0];
`else
        mod = 20'(mod_sum) <<< mod_sh;
`endif
        phase_d = 10'((phase_cnt + mod) >> 10);
    end

    always_comb begin
        unique case (con)
            3'd0, 3'd1, 3'd2, 3'd3: car_d = (op == 2'd3);
            3'd4:                   car_d = op[1];
            3'd5, 3'd6:             car_d = (op != 2'd0);
            default:                car_d = 1'b1;
        endcase
    end

    always_comb begin
        s3_logsum_d = {1'b0, sin_log(s2_addr_q)} + {1'b0, s2_eg_q, 2'b00};
        s5_abs_d    = (s4_msb_q <= 5'd12) ? (s4_pre_q >> s4_msb_q) : '0;
        s6_v_d      = s5_sign_q ? -$signed({1'b0, s5_abs_q}) : $signed({1'b0, s5_abs_q});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            vcnt_q      <= '0;
            s1_phase_q  <= '0; s1_eg_q <= '0; s1_slot_q <= '0; s1_car_q <= 1'b0;
            s2_addr_q   <= '0; s2_eg_q <= '0; s2_sign_q <= 1'b0; s2_car_q <= 1'b0; s2_slot_q <= '0;
            s3_msb_q    <= '0; s3_paddr_q <= '0; s3_sign_q <= 1'b0; s3_car_q <= 1'b0; s3_slot_q <= '0;
            s4_pre_q    <= '0; s4_msb_q <= '0; s4_sign_q <= 1'b0; s4_car_q <= 1'b0; s4_slot_q <= '0;
            s5_abs_q    <= '0; s5_sign_q <= 1'b0; s5_car_q <= 1'b0; s5_slot_q <= '0;
            s6_v_q      <= '0; s6_car_q <= 1'b0; s6_slot_q <= '0;
            hist_cur_q  <= '{default: '0};
            hist_prev_q <= '{default: '0};
            out         <= '0;
            out_valid   <= 1'b0;
            out_ch      <= '0;
            out_op      <= '0;
        end else if (cen) begin
            cnt_q      <= cnt_d;
            vcnt_q     <= (vcnt_q == 3'd6) ? 3'd6 : vcnt_q + 3'd1;
            s1_phase_q <= phase_d;
            s1_eg_q    <= eg;
            s1_slot_q  <= slot;
            s1_car_q   <= car_d;
            s2_addr_q  <= s1_phase_q[8] ? ~s1_phase_q[7:0] : s1_phase_q[7:0];
            s2_sign_q  <= s1_phase_q[9];
            s2_eg_q    <= s1_eg_q;
            s2_car_q   <= s1_car_q;
            s2_slot_q  <= s1_slot_q;
            s3_msb_q   <= s3_logsum_d[12:8];
            s3_paddr_q <= s3_logsum_d[7:0];
            s3_sign_q  <= s2_sign_q;
            s3_car_q   <= s2_car_q;
            s3_slot_q  <= s2_slot_q;
            s4_pre_q   <= exp_pow(s3_paddr_q);
            s4_msb_q   <= s3_msb_q;
            s4_sign_q  <= s3_sign_q;
            s4_car_q   <= s3_car_q;
            s4_slot_q  <= s3_slot_q;
            s5_abs_q   <= s5_abs_d;
            s5_sign_q  <= s4_sign_q;
            s5_car_q   <= s4_car_q;
            s5_slot_q  <= s4_slot_q;
            s6_v_q     <= s6_v_d;
            s6_car_q   <= s5_car_q;
            s6_slot_q  <= s5_slot_q;
            hist_prev_q[s5_slot_q] <= hist_cur_q[s5_slot_q];
            hist_cur_q[s5_slot_q]  <= s6_v_d;
            out        <= s6_car_q ? s6_v_q : '0;
            out_valid  <= (vcnt_q == 3'd6);
            out_ch     <= 4'(32'(s6_slot_q) % CH);
            out_op     <= 2'(32'(s6_slot_q) / CH);
        end
    end
endmodule
